// File: rtl/weight_loader.sv
// Weight loader: fetches N consecutive weights from a word-addressed memory over a
// req/ack port and writes each one to the weight register bank as a one-cycle strobe.
module weight_loader #(
  parameter int unsigned bit_width = 32,
  parameter int unsigned N         = 9,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned IDX_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_ack,
  input  logic [bit_width-1:0] mem_data,
  output logic                 write,
  output logic [IDX_W-1:0]     weight_index,
  output logic [bit_width-1:0] weight_out
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWrite, StDone} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]    base_q, base_d;

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic                 write_q, write_d;
  logic [IDX_W-1:0]     weight_index_q, weight_index_d;
  logic [bit_width-1:0] weight_out_q, weight_out_d;

  // State, slot counter and latched base address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
    end
  end

  // Next-state logic: one REQ/WRITE pair per weight, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          base_d  = base_addr;
          idx_d   = '0;
        end
      end
      StReq: begin
        if (mem_ack) state_d = StWrite;
      end
      StWrite: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StReq;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: next values of the registered outputs, decoded from the next state so
  // every output lines up with the cycle its state is occupied.
  always_comb begin
    busy_d         = (state_d != StIdle);
    done_d         = (state_d == StDone);
    mem_req_d      = (state_d == StReq);
    write_d        = (state_d == StWrite);
    mem_addr_d     = mem_addr_q;
    weight_index_d = weight_index_q;
    weight_out_d   = weight_out_q;
    // Address wraps modulo 2^ADDR_W.
    if (state_d == StReq) mem_addr_d = base_d + ADDR_W'(idx_d);
    // Capture only on a requested ack; stray acks outside REQ are dropped.
    if (state_q == StReq && mem_ack) begin
      weight_index_d = idx_q;
      weight_out_d   = mem_data;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      write_q        <= 1'b0;
      weight_index_q <= '0;
      weight_out_q   <= '0;
    end else begin
      busy_q         <= busy_d;
      done_q         <= done_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
      write_q        <= write_d;
      weight_index_q <= weight_index_d;
      weight_out_q   <= weight_out_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign write        = write_q;
  assign weight_index = weight_index_q;
  assign weight_out   = weight_out_q;

endmodule

// File: tb/tb_weight_loader.sv
// Testbench for weight_loader: memory responder with programmable ack delay and a
// reference model of the expected (index, weight, cycle) sequence for each load.
module tb_weight_loader;

  localparam int BW = 32;
  localparam int N  = 9;
  localparam int AW = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          busy, done, mem_req, write;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [BW-1:0] mem_data;
  logic [IW-1:0] weight_index;
  logic [BW-1:0] weight_out;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [BW-1:0] key;
  int            fixed_delay;
  bit            rand_delay;
  bit            force_ack;
  int            delay_log[$];

  always #5 clk = ~clk;

  weight_loader #(
    .bit_width(BW),
    .N        (N),
    .ADDR_W   (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .busy        (busy),
    .done        (done),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .write       (write),
    .weight_index(weight_index),
    .weight_out  (weight_out)
  );

  // Memory contents: word at address a holds a + key.
  function automatic logic [BW-1:0] mem_fn(input logic [AW-1:0] a);
    return BW'(a) + key;
  endfunction

  // Memory responder: acks a request after cur_delay wait cycles, same-cycle data.
  initial begin : responder
    int wait_cnt;
    int cur_delay;
    wait_cnt  = 0;
    cur_delay = 0;
    mem_ack   = 1'b0;
    mem_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (wait_cnt >= cur_delay) begin
          mem_ack  = 1'b1;
          mem_data = mem_fn(mem_addr);
          delay_log.push_back(cur_delay);
        end else begin
          mem_ack  = 1'b0;
          mem_data = $urandom;
          wait_cnt++;
        end
      end else begin
        mem_ack   = force_ack;
        mem_data  = $urandom;
        wait_cnt  = 0;
        cur_delay = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // One full load from base; checks addresses, write order/data/timing, busy, done.
  task automatic run_load(input logic [AW-1:0] base, input int exp_done, input bit poke,
                          input bit hold);
    int k, dsum, tot, done_cyc;
    bit seen_done;
    logic [AW-1:0] ea;
    delay_log.delete();
    k = 0; dsum = 0; tot = 0; done_cyc = -1; seen_done = 0;
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    for (int c = 1; c <= 250 && !seen_done; c++) begin
      @(negedge clk);
      if (!hold) begin
        start = poke && (c == 1);
        base_addr = $urandom;
      end
      n_cmp++;
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL load_busy: cycle %0d busy=%b required 1", c, busy);
      end
      if (mem_req) begin
        ea = base + AW'(k);
        n_cmp++;
        if (mem_addr !== ea) begin
          n_fail++; $display("FAIL load_addr: cycle %0d mem_addr=%h required %h", c, mem_addr, ea);
        end
      end
      if (write) begin
        if (k < delay_log.size()) dsum += delay_log[k];
        ea = base + AW'(k);
        n_cmp++;
        if (weight_index !== IW'(k) || weight_out !== mem_fn(ea) || mem_req !== 1'b0 ||
            c != 2 * (k + 1) + dsum) begin
          n_fail++;
          $display("FAIL load_write: cycle %0d idx=%0d data=%h req=%b required cycle %0d idx=%0d data=%h req=0",
                   c, weight_index, weight_out, mem_req, 2 * (k + 1) + dsum, k, mem_fn(ea));
        end
        k++;
      end
      if (done) begin
        seen_done = 1'b1;
        done_cyc  = c;
        if (poke) start = 1'b1;
      end
    end
    foreach (delay_log[i]) tot += delay_log[i];
    n_cmp++;
    if (k != N) begin
      n_fail++; $display("FAIL load_count: writes=%0d required %0d", k, N);
    end
    n_cmp++;
    if (done_cyc != 2 * N + 1 + tot) begin
      n_fail++; $display("FAIL load_done: done at cycle %0d required %0d", done_cyc, 2 * N + 1 + tot);
    end
    if (exp_done >= 0) begin
      n_cmp++;
      if (done_cyc != exp_done) begin
        n_fail++; $display("FAIL load_done_fixed: done at cycle %0d required %0d", done_cyc, exp_done);
      end
    end
    @(negedge clk);
    if (!hold) start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || write !== 1'b0) begin
      n_fail++; $display("FAIL load_end: busy=%b done=%b write=%b required 0 0 0", busy, done, write);
    end
    if (poke) begin
      repeat (3) begin
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || write !== 1'b0) begin
          n_fail++;
          $display("FAIL no_restart: mem_req=%b busy=%b write=%b required 0 0 0", mem_req, busy, write);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_addr = '0; force_ack = 1'b0;
    fixed_delay = 0; rand_delay = 1'b0; key = 32'h1000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, mem_req, write, mem_addr, weight_index, weight_out} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle: cycle %0d busy=%b done=%b req=%b wr=%b addr=%h idx=%h w=%h required all 0",
                 i, busy, done, mem_req, write, mem_addr, weight_index, weight_out);
      end
    end
  endtask

  task automatic test_basic();
    key = 32'h1000; fixed_delay = 0; rand_delay = 1'b0;
    run_load(16'h0100, 19, 1'b0, 1'b0);
  endtask

  task automatic test_ack_delay();
    key = 32'h1000; fixed_delay = 3; rand_delay = 1'b0;
    run_load(16'h0100, 46, 1'b0, 1'b0);
    fixed_delay = 0;
  endtask

  task automatic test_wrap();
    key = 32'h5A5A0000; fixed_delay = 0; rand_delay = 1'b0;
    run_load(16'hFFFE, 19, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    rand_delay = 1'b1;
    repeat (4) begin
      key = $urandom;
      run_load(AW'($urandom), -1, 1'b0, 1'b0);
    end
    rand_delay = 1'b0;
  endtask

  task automatic test_ignored_start();
    key = 32'h0BAD0000;
    force_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (write !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_ack: cycle %0d write=%b req=%b busy=%b required 0 0 0", i, write, mem_req, busy);
      end
    end
    force_ack = 1'b0;
    @(negedge clk);
    run_load(16'h2000, 19, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int k;
    bit seen_done;
    key = 32'h00C0FFEE;
    run_load(16'h0300, 19, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0300 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_restart: req=%b addr=%h busy=%b required 1 0300 1", mem_req, mem_addr, busy);
    end
    k = 0; seen_done = 0;
    for (int c = 0; c < 100 && !seen_done; c++) begin
      @(negedge clk);
      if (write) begin
        n_cmp++;
        if (weight_index !== IW'(k) || weight_out !== mem_fn(16'h0300 + AW'(k))) begin
          n_fail++;
          $display("FAIL b2b_write: idx=%0d data=%h required idx=%0d data=%h",
                   weight_index, weight_out, k, mem_fn(16'h0300 + AW'(k)));
        end
        k++;
      end
      if (done) seen_done = 1'b1;
    end
    n_cmp++;
    if (!seen_done || k != N) begin
      n_fail++; $display("FAIL b2b_count: done=%b writes=%0d required 1 %0d", seen_done, k, N);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    key = 32'h77770000; fixed_delay = 0; rand_delay = 1'b0;
    k = 0;
    @(negedge clk);
    start = 1'b1;
    base_addr = 16'h0400;
    for (int c = 1; c <= 60 && k < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (write) k++;
    end
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1 || k != 4) begin
      n_fail++; $display("FAIL mid_pre: req=%b writes=%0d required 1 4", mem_req, k);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, mem_req, write, mem_addr, weight_index, weight_out} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b done=%b req=%b wr=%b addr=%h idx=%h w=%h required all 0",
               busy, done, mem_req, write, mem_addr, weight_index, weight_out);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_cmp++;
      if (write !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_after: cycle %0d write=%b done=%b busy=%b required 0 0 0", i, write, done, busy);
      end
    end
    run_load(16'h0400, 19, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_delay();
    test_wrap();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Writer side of the convolver weight-register interface.
- On a start command it fetches N consecutive weights from a word-addressed weight memory through a req/ack port.
- It presents each weight to the weight register bank as a one-cycle write strobe, with the data and a slot index.
- It sits between the weight memory/controller and the weight register bank feeding the convolver.

Parameters:
- bit_width, 32, width of one weight word.
- N, 9, number of weights per kernel (register slots); N >= 1.
- ADDR_W, 16, width of the weight memory address.
- IDX_W, $clog2(N) (minimum 1), width of the slot index.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  load request; sampled only in IDLE.
- base_addr  input  ADDR_W  address of weight 0; latched when start is accepted.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle pulse after the last weight is written.
- mem_req  output  1  read request to the weight memory.
- mem_addr  output  ADDR_W  read address; valid while mem_req is high.
- mem_ack  input  1  memory handshake; mem_data is valid in the same cycle.
- mem_data  input  bit_width  read data.
- write  output  1  one-cycle write strobe to the weight register bank.
- weight_index  output  IDX_W  target slot for the write.
- weight_out  output  bit_width  weight value for the write.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; idx=0; address register=0.
- Reset values: busy=0, done=0, mem_req=0, mem_addr=0, write=0, weight_index=0, weight_out=0.
- Reset asserted mid-load aborts the load: no further write or done pulse, and any pending ack is discarded.
- All outputs are registered.
- States: IDLE, REQ, WRITE, DONE.
- IDLE:
  - start=1 latches base_addr and sets idx=0; next state REQ.
  - start=0 stays in IDLE.
- REQ:
  - mem_req=1, mem_addr=base_addr+idx (modulo 2^ADDR_W; wraps without error).
  - mem_req, mem_addr and idx are held stable until mem_ack=1.
  - On the mem_ack cycle: mem_data is captured into weight_out and idx into weight_index; next state WRITE.
- WRITE (exactly one cycle):
  - write=1, mem_req=0.
  - idx==N-1: next state DONE. Otherwise idx increments and next state is REQ.
- DONE (one cycle): done=1, busy=1; next state IDLE.
- start:
  - Ignored while busy, including in the DONE cycle.
  - A start held high continuously begins a new load in the first IDLE cycle after DONE.
- mem_ack while mem_req=0 is ignored.
- Extra ack cycles do not generate extra writes.
- Between writes, weight_out and weight_index hold their last values; write=0 outside WRITE.
- Timing, with mem_ack high whenever requested and start sampled at edge 0:
  - REQ occupies cycles 1,3,5,…; write pulses occur at cycles 2,4,…,2N.
  - done pulses at cycle 2N+1 (cycle 19 for N=9); busy falls at cycle 2N+2.
- Each cycle of ack wait adds one cycle to the total latency.
- Writes are issued in strictly ascending index order 0..N-1, exactly one per index per load.

Test Plan:
- Reset, then idle for 5 cycles -> all outputs 0; no write, no mem_req.
- start with base_addr=0x0100; memory returns data=addr+0x1000 with same-cycle ack -> 9 write pulses at cycles 2..18.
  - Pairs (index k, weight 0x1100+k) for k=0..8; mem_addr 0x0100..0x0108.
  - done only at cycle 19.
- Same load with mem_ack delayed 3 cycles on every request -> mem_addr and mem_req held stable while waiting; identical data/index sequence; done at cycle 19+27=46.
- base_addr=0xFFFE, N=9 -> mem_addr sequence FFFE, FFFF, 0000…0006; all 9 writes correct.
- start pulsed during REQ and during DONE; mem_ack pulsed while idle -> no restart and no extra write.
  - start held high across DONE -> second load begins the cycle after DONE.
- reset asserted while in REQ after the 4th write -> outputs 0 immediately, before the next clock edge.
  - No write or done afterwards.
  - A subsequent start performs a full 9-weight load from index 0.
